// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that drains one byte at a time into the UART send stage
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int TO_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WrEn,
  input  logic [7:0]    WrData,
  output logic          Full,
  output logic          Empty,
  output logic [AW:0]   Count,
  output logic          Overflow,
  output logic          Timeout,
  output logic          SendEn,
  output logic [7:0]    SendData,
  input  logic          SendBusy,
  input  logic          SendDone
);
  typedef enum logic {sIdle, sWait} stateT;
  stateT state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [15:0] wdCnt;
  logic accept, pop;
  assign Full = Count == (AW+1)'(DEPTH);
  assign Empty = Count == '0;
  assign accept = WrEn && !Full;
  assign pop = state == sIdle && !Empty && !SendBusy;
  // Byte storage; contents need no reset since Count gates every read
  always_ff @(posedge clk)
    if (accept) mem[wrPtr] <= WrData;
  // Pointers, occupancy and the overflow pulse for rejected writes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
      Overflow <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      Count <= Count + (AW+1)'(accept) - (AW+1)'(pop);
      Overflow <= WrEn && Full;
    end
  // Issue FSM: pop and strobe one byte, then wait for SendDone or the watchdog
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= sIdle;
      SendEn <= 1'b0;
      SendData <= '0;
      Timeout <= 1'b0;
      wdCnt <= '0;
    end else begin
      SendEn <= pop;
      Timeout <= 1'b0;
      if (state == sIdle) begin
        if (pop) begin
          SendData <= mem[rdPtr];
          wdCnt <= '0;
          state <= sWait;
        end
      end else if (SendDone) state <= sIdle;
      else if (wdCnt == 16'(TO_CYCLES - 1)) begin
        Timeout <= 1'b1;
        state <= sIdle;
      end else wdCnt <= wdCnt + 1'b1;
    end
endmodule
